// File: rtl/ro_sequencer_pkg.sv
// Shared types and constants for the ring-buffer readout sequencer.
// Holds the FSM state encoding and the SPI header word layout.
package ro_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_HEADER = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int          HDR_W        = 16;
  localparam logic [1:0]  HDR_MARKER   = 2'b10;
  localparam int          HDR_MARK_LSB = 14;
  localparam int          HDR_CH_LSB   = 12;
  localparam int          HDR_CNT_W    = 12;

  // Header word: {marker, channel, word count}.
  function automatic logic [HDR_W-1:0] makeHeader(input logic [1:0]           ch,
                                                  input logic [HDR_CNT_W-1:0] cnt);
    logic [HDR_W-1:0] hdr;
    hdr = '0;
    hdr[HDR_MARK_LSB +: 2] = HDR_MARKER;
    hdr[HDR_CH_LSB +: 2]   = ch;
    hdr[HDR_CNT_W-1:0]     = cnt;
    return hdr;
  endfunction

endpackage

// File: rtl/ro_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: the scan starts one past the last grant,
// so the most recently served channel has the lowest priority.
module rr_arbiter
  import ro_sequencer_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0] i_req,
  input  logic [1:0]     i_lastGrant,
  output logic [NCH-1:0] o_grantOnehot,
  output logic [1:0]     o_grantIdx,
  output logic           o_valid
);

  logic [1:0] w_scanIdx;

  always_comb begin
    o_grantOnehot = '0;
    o_grantIdx    = '0;
    o_valid       = 1'b0;
    w_scanIdx     = '0;
    for (int k = 1; k <= NCH; k++) begin
      w_scanIdx = 2'((int'(i_lastGrant) + k) % NCH);
      if (!o_valid && i_req[w_scanIdx]) begin
        o_valid                  = 1'b1;
        o_grantIdx               = w_scanIdx;
        o_grantOnehot[w_scanIdx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ro_sequencer.sv
// Multi-channel readout sequencer: latches trigger edges, grants channels
// round-robin and paces one header plus N data words over the SPI link.
module ro_sequencer
  import ro_sequencer_pkg::*;
#(
  parameter int SIZE    = 12,
  parameter int NCH     = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic [NCH-1:0]    trig_i,
  input  logic [SIZE-1:0]   wr_addr_i,
  input  logic [SIZE-1:0]   offset_cfg_i,
  input  logic [SIZE-1:0]   howmany_cfg_i,
  input  logic              err_clr_i,
  input  logic              ro_done_n_i,
  input  logic              spi_done_i,
  output logic              rd_request_o,
  output logic [SIZE-1:0]   ain_o,
  output logic [SIZE-1:0]   offset_o,
  output logic [SIZE-1:0]   howmany_o,
  output logic              word_adv_o,
  output logic [1:0]        ch_sel_o,
  output logic              spi_start_o,
  output logic              hdr_sel_o,
  output logic [HDR_W-1:0]  hdr_o,
  output logic [NCH-1:0]    ack_o,
  output logic [NCH-1:0]    overrun_o,
  output logic              err_timeout_o
);

  localparam int             WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [NCH-1:0]   r_trigQ;
  logic [NCH-1:0]   r_pending;
  logic [NCH-1:0]   r_overrun;
  logic             r_errTimeout;
  logic [1:0]       r_lastGrant;
  logic [1:0]       r_chSel;
  logic [SIZE-1:0]  r_ain;
  logic [SIZE-1:0]  r_offset;
  logic [SIZE-1:0]  r_howmany;
  logic [HDR_W-1:0] r_hdr;
  logic             r_spiStart;
  logic [NCH-1:0]   r_ack;
  logic [WD_W-1:0]  r_wdog;

  logic [NCH-1:0]   w_edge;
  logic [NCH-1:0]   w_grantOnehot;
  logic [1:0]       w_grantIdx;
  logic             w_grantValid;
  logic [NCH-1:0]   w_consume;
  logic [NCH-1:0]   w_chOnehot;
  logic             w_startNext;
  logic             w_timeout;
  logic             w_grantTake;

  assign w_edge     = trig_i & ~r_trigQ;
  assign w_chOnehot = NCH'(1) << r_chSel;
  // The granted request is consumed at grant time, so a re-trigger of the
  // channel in service queues a fresh event instead of counting as overrun.
  assign w_consume  = w_grantTake ? w_grantOnehot : '0;

  rr_arbiter #(.NCH(NCH)) u_arbiter (
    .i_req         (r_pending),
    .i_lastGrant   (r_lastGrant),
    .o_grantOnehot (w_grantOnehot),
    .o_grantIdx    (w_grantIdx),
    .o_valid       (w_grantValid)
  );

  always_comb begin
    w_nextState = r_state;
    w_startNext = 1'b0;
    w_timeout   = 1'b0;
    w_grantTake = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_grantValid) begin
          w_grantTake = 1'b1;
          w_nextState = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_nextState = ST_HEADER;
        w_startNext = 1'b1;
      end
      ST_HEADER: begin
        if (spi_done_i) begin
          if (r_howmany == '0) begin
            w_nextState = ST_DONE;
          end else begin
            w_nextState = ST_DATA;
            w_startNext = 1'b1;
          end
        end else if (r_wdog == WD_LAST) begin
          w_timeout   = 1'b1;
          w_nextState = ST_DONE;
        end
      end
      ST_DATA: begin
        if (spi_done_i) begin
          if (!ro_done_n_i) begin
            w_nextState = ST_DONE;
          end else begin
            w_startNext = 1'b1;
          end
        end else if (r_wdog == WD_LAST) begin
          w_timeout   = 1'b1;
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_trigQ      <= '0;
      r_pending    <= '0;
      r_overrun    <= '0;
      r_errTimeout <= 1'b0;
      r_lastGrant  <= 2'(NCH - 1);
      r_chSel      <= '0;
      r_ain        <= '0;
      r_offset     <= '0;
      r_howmany    <= '0;
      r_hdr        <= '0;
      r_spiStart   <= 1'b0;
      r_ack        <= '0;
    end else begin
      r_state      <= w_nextState;
      r_trigQ      <= trig_i;
      r_pending    <= (r_pending & ~w_consume) | w_edge;
      r_overrun    <= (err_clr_i ? '0 : r_overrun) | (w_edge & r_pending);
      r_errTimeout <= w_timeout | (r_errTimeout & ~err_clr_i);
      r_spiStart   <= w_startNext;
      r_ack        <= (w_nextState == ST_DONE) ? w_chOnehot : '0;
      if (w_grantTake) begin
        r_chSel   <= w_grantIdx;
        r_ain     <= wr_addr_i;
        r_offset  <= offset_cfg_i;
        r_howmany <= howmany_cfg_i;
        r_hdr     <= makeHeader(w_grantIdx, HDR_CNT_W'(howmany_cfg_i));
      end
      if (r_state == ST_DONE) begin
        r_lastGrant <= r_chSel;
      end
    end
  end

  // Watchdog restarts with every word start and saturates at its limit.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_wdog <= '0;
    end else if (w_startNext) begin
      r_wdog <= '0;
    end else if ((r_state == ST_HEADER || r_state == ST_DATA) && r_wdog != WD_LAST) begin
      r_wdog <= r_wdog + WD_W'(1);
    end
  end

  assign rd_request_o  = (r_state == ST_HEADER) || (r_state == ST_DATA);
  assign hdr_sel_o     = (r_state == ST_HEADER);
  assign word_adv_o    = (r_state == ST_DATA) && spi_done_i;
  assign spi_start_o   = r_spiStart;
  assign ack_o         = r_ack;
  assign ch_sel_o      = r_chSel;
  assign ain_o         = r_ain;
  assign offset_o      = r_offset;
  assign howmany_o     = r_howmany;
  assign hdr_o         = r_hdr;
  assign overrun_o     = r_overrun;
  assign err_timeout_o = r_errTimeout;

endmodule

// File: tb/tb_ro_sequencer.sv
// Directed bench for ro_sequencer with a small SPI responder and an
// address-controller model that drives ro_done_n_i from the word count.
module tb_ro_sequencer;

  localparam int SIZE      = 12;
  localparam int NCH       = 4;
  localparam int TIMEOUT   = 64;
  localparam int SPI_DELAY = 2;

  logic            sysclk;
  logic            rst;
  logic [NCH-1:0]  trig_i;
  logic [SIZE-1:0] wr_addr_i;
  logic [SIZE-1:0] offset_cfg_i;
  logic [SIZE-1:0] howmany_cfg_i;
  logic            err_clr_i;
  logic            ro_done_n_i;
  logic            spi_done_i;
  logic            rd_request_o;
  logic [SIZE-1:0] ain_o;
  logic [SIZE-1:0] offset_o;
  logic [SIZE-1:0] howmany_o;
  logic            word_adv_o;
  logic [1:0]      ch_sel_o;
  logic            spi_start_o;
  logic            hdr_sel_o;
  logic [15:0]     hdr_o;
  logic [NCH-1:0]  ack_o;
  logic [NCH-1:0]  overrun_o;
  logic            err_timeout_o;

  int checks   = 0;
  int failures = 0;

  int cycleCount     = 0;
  int advCnt         = 0;
  int advTotal       = 0;
  int startTotal     = 0;
  int lastStartCycle = 0;
  int lastDoneCycle  = 0;
  int spiRespondLeft = -1;
  int doneIn         = 0;
  logic [NCH-1:0] ackLog[$];
  int             ackCycle[$];

  ro_sequencer #(.SIZE(SIZE), .NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
    .sysclk        (sysclk),
    .rst           (rst),
    .trig_i        (trig_i),
    .wr_addr_i     (wr_addr_i),
    .offset_cfg_i  (offset_cfg_i),
    .howmany_cfg_i (howmany_cfg_i),
    .err_clr_i     (err_clr_i),
    .ro_done_n_i   (ro_done_n_i),
    .spi_done_i    (spi_done_i),
    .rd_request_o  (rd_request_o),
    .ain_o         (ain_o),
    .offset_o      (offset_o),
    .howmany_o     (howmany_o),
    .word_adv_o    (word_adv_o),
    .ch_sel_o      (ch_sel_o),
    .spi_start_o   (spi_start_o),
    .hdr_sel_o     (hdr_sel_o),
    .hdr_o         (hdr_o),
    .ack_o         (ack_o),
    .overrun_o     (overrun_o),
    .err_timeout_o (err_timeout_o)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  // SPI transmitter model: answers each start with a done pulse SPI_DELAY
  // cycles later, unless the response budget is exhausted.
  initial begin
    spi_done_i = 1'b0;
    forever begin
      @(posedge sysclk);
      #2;
      spi_done_i = 1'b0;
      if (rst) begin
        doneIn = 0;
      end else begin
        if (doneIn > 0) begin
          doneIn--;
          if (doneIn == 0) spi_done_i = 1'b1;
        end
        if (spi_start_o && spiRespondLeft != 0) begin
          doneIn = SPI_DELAY;
          if (spiRespondLeft > 0) spiRespondLeft--;
        end
      end
    end
  end

  // Address-controller model and event monitor, sampled mid-cycle.
  initial begin
    ro_done_n_i = 1'b1;
    forever begin
      @(negedge sysclk);
      cycleCount++;
      if (rst || !rd_request_o) begin
        advCnt      = 0;
        ro_done_n_i = 1'b1;
      end else begin
        ro_done_n_i = !((advCnt + 1) >= int'(howmany_o));
        if (word_adv_o) advCnt++;
      end
      if (word_adv_o) advTotal++;
      if (spi_start_o) begin
        startTotal++;
        lastStartCycle = cycleCount;
      end
      if (spi_done_i && rd_request_o) lastDoneCycle = cycleCount;
      if (ack_o != '0) begin
        ackLog.push_back(ack_o);
        ackCycle.push_back(cycleCount);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] trig, input int cycles);
    trig_i = trig;
    repeat (cycles) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic applyReset();
    rst       = 1'b1;
    trig_i    = '0;
    err_clr_i = 1'b0;
    repeat (3) begin
      @(posedge sysclk);
      #1;
    end
    rst = 1'b0;
    @(posedge sysclk);
    #1;
  endtask

  task automatic waitAcks(input int target, input int budget, input string tag);
    int cyc;
    cyc = 0;
    while (ackLog.size() < target && cyc < budget) begin
      @(posedge sysclk);
      #1;
      cyc++;
    end
    checkOutput(tag, 32'(ackLog.size()), 32'(target));
  endtask

  initial begin
    int base;
    int startBase;
    int advBase;
    int found;
    int startAtData;

    rst           = 1'b1;
    trig_i        = '0;
    wr_addr_i     = '0;
    offset_cfg_i  = '0;
    howmany_cfg_i = '0;
    err_clr_i     = 1'b0;
    applyReset();

    $display("[TB] reset values");
    checkOutput("rst_rd_request", 32'(rd_request_o), 32'd0);
    checkOutput("rst_spi_start",  32'(spi_start_o),  32'd0);
    checkOutput("rst_ack",        32'(ack_o),        32'd0);
    checkOutput("rst_hdr_sel",    32'(hdr_sel_o),    32'd0);
    checkOutput("rst_hdr",        32'(hdr_o),        32'd0);
    checkOutput("rst_ch_sel",     32'(ch_sel_o),     32'd0);
    checkOutput("rst_cfg",        32'({ain_o, offset_o, howmany_o}), 32'd0);
    checkOutput("rst_errors",     32'({overrun_o, err_timeout_o}), 32'd0);

    $display("[TB] single event ch1, howmany=3");
    wr_addr_i     = 12'h123;
    offset_cfg_i  = 12'h010;
    howmany_cfg_i = 12'd3;
    base      = ackLog.size();
    startBase = startTotal;
    advBase   = advTotal;
    applyStimulus(4'b0010, 1);
    applyStimulus(4'b0010, 1);
    checkOutput("t1_load_rd_request", 32'(rd_request_o), 32'd0);
    checkOutput("t1_load_spi_start",  32'(spi_start_o),  32'd0);
    checkOutput("t1_hdr",             32'(hdr_o),        32'h9003);
    applyStimulus(4'b0000, 1);
    checkOutput("t1_hdr_start", 32'({spi_start_o, hdr_sel_o, rd_request_o}), 32'b111);
    wr_addr_i     = 12'hABC;
    offset_cfg_i  = 12'h055;
    howmany_cfg_i = 12'd7;
    waitAcks(base + 1, 200, "t1_ack_count");
    checkOutput("t1_ack",        32'(ackLog[base]), 32'b0010);
    checkOutput("t1_ack_delay",  32'(ackCycle[base] - lastDoneCycle), 32'd1);
    checkOutput("t1_starts",     32'(startTotal - startBase), 32'd4);
    checkOutput("t1_word_adv",   32'(advTotal - advBase), 32'd3);
    checkOutput("t1_frozen_cfg", 32'({ain_o, offset_o}), 32'({12'h123, 12'h010}));
    checkOutput("t1_frozen_cnt", 32'(howmany_o), 32'd3);
    checkOutput("t1_ch_sel",     32'(ch_sel_o), 32'd1);

    $display("[TB] header-only event ch0, howmany=0");
    howmany_cfg_i = 12'd0;
    wr_addr_i     = 12'h7FE;
    base      = ackLog.size();
    startBase = startTotal;
    advBase   = advTotal;
    applyStimulus(4'b0001, 1);
    applyStimulus(4'b0000, 2);
    checkOutput("t2_hdr", 32'(hdr_o), 32'h8000);
    waitAcks(base + 1, 100, "t2_ack_count");
    checkOutput("t2_ack",       32'(ackLog[base]), 32'b0001);
    checkOutput("t2_ack_delay", 32'(ackCycle[base] - lastDoneCycle), 32'd1);
    checkOutput("t2_starts",    32'(startTotal - startBase), 32'd1);
    checkOutput("t2_word_adv",  32'(advTotal - advBase), 32'd0);
    checkOutput("t2_ain",       32'(ain_o), 32'h7FE);

    $display("[TB] round-robin 0,2 then re-trigger 0");
    applyReset();
    howmany_cfg_i = 12'd1;
    base = ackLog.size();
    applyStimulus(4'b0101, 3);
    applyStimulus(4'b0100, 1);
    applyStimulus(4'b0101, 1);
    applyStimulus(4'b0000, 1);
    waitAcks(base + 3, 300, "t3_ack_count");
    checkOutput("t3_order0", 32'(ackLog[base]),     32'b0001);
    checkOutput("t3_order1", 32'(ackLog[base + 1]), 32'b0100);
    checkOutput("t3_order2", 32'(ackLog[base + 2]), 32'b0001);
    checkOutput("t3_overrun", 32'(overrun_o), 32'd0);

    $display("[TB] overrun on ch3");
    base = ackLog.size();
    applyStimulus(4'b1010, 2);
    applyStimulus(4'b0010, 1);
    applyStimulus(4'b1010, 1);
    checkOutput("t4_overrun_set", 32'(overrun_o), 32'b1000);
    applyStimulus(4'b0000, 1);
    waitAcks(base + 2, 300, "t4_ack_count");
    checkOutput("t4_ack0", 32'(ackLog[base]),     32'b0010);
    checkOutput("t4_ack1", 32'(ackLog[base + 1]), 32'b1000);
    applyStimulus(4'b0000, 20);
    checkOutput("t4_ch3_once", 32'(ackLog.size()), 32'(base + 2));
    checkOutput("t4_overrun_sticky", 32'(overrun_o), 32'b1000);
    err_clr_i = 1'b1;
    applyStimulus(4'b0000, 1);
    err_clr_i = 1'b0;
    checkOutput("t4_overrun_clr", 32'(overrun_o), 32'd0);

    $display("[TB] watchdog in DATA");
    howmany_cfg_i  = 12'd3;
    spiRespondLeft = 1;
    base = ackLog.size();
    checkOutput("t5_err_before", 32'(err_timeout_o), 32'd0);
    applyStimulus(4'b0101, 1);
    applyStimulus(4'b0000, 1);
    waitAcks(base + 1, TIMEOUT + 40, "t5_ack_count");
    startAtData    = lastStartCycle;
    spiRespondLeft = -1;
    checkOutput("t5_err_timeout", 32'(err_timeout_o), 32'd1);
    if (ackLog.size() > base) begin
      checkOutput("t5_ack0", 32'(ackLog[base]), 32'b0001);
      checkOutput("t5_wdog_len", 32'(ackCycle[base] - startAtData), 32'(TIMEOUT));
    end
    waitAcks(base + 2, 200, "t5_next_ack_count");
    if (ackLog.size() > base + 1) begin
      checkOutput("t5_ack1", 32'(ackLog[base + 1]), 32'b0100);
    end
    checkOutput("t5_err_sticky", 32'(err_timeout_o), 32'd1);
    err_clr_i = 1'b1;
    applyStimulus(4'b0000, 1);
    err_clr_i = 1'b0;
    checkOutput("t5_err_clr", 32'(err_timeout_o), 32'd0);

    $display("[TB] reset mid-DATA");
    howmany_cfg_i = 12'd3;
    wr_addr_i     = 12'h321;
    applyStimulus(4'b0010, 1);
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(posedge sysclk);
      #1;
      if (rd_request_o && !hdr_sel_o) found = 1;
    end
    checkOutput("t6_reached_data", 32'(found), 32'd1);
    rst    = 1'b1;
    trig_i = '0;
    @(posedge sysclk);
    #1;
    checkOutput("t6_rd_request", 32'(rd_request_o), 32'd0);
    checkOutput("t6_outputs", 32'({spi_start_o, hdr_sel_o, ack_o, ch_sel_o, hdr_o}), 32'd0);
    checkOutput("t6_cfg", 32'({ain_o, howmany_o}), 32'd0);
    @(posedge sysclk);
    #1;
    rst = 1'b0;
    applyStimulus(4'b0000, 2);
    howmany_cfg_i = 12'd2;
    base      = ackLog.size();
    startBase = startTotal;
    advBase   = advTotal;
    applyStimulus(4'b0100, 1);
    applyStimulus(4'b0000, 1);
    waitAcks(base + 1, 200, "t6_ack_count");
    if (ackLog.size() > base) begin
      checkOutput("t6_ack", 32'(ackLog[base]), 32'b0100);
    end
    checkOutput("t6_starts",   32'(startTotal - startBase), 32'd3);
    checkOutput("t6_word_adv", 32'(advTotal - advBase), 32'd2);
    checkOutput("t6_hdr",      32'(hdr_o), 32'hA002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
